// File: rtl/div_share_pkg.sv
// -----------------------------------------------------------------------------
// div_share_pkg
// Shared definitions for the time-multiplexed divider controller:
//   - default values for NUM_REQ / DATA_W
//   - controller state encoding (IDLE -> CALC -> RESP)
//   - id_w(): width of a requester index, never less than one bit
// Optional build macro used by this slice: DIV_SHARE_STATS_EN
// -----------------------------------------------------------------------------
package div_share_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic int id_w(input int n);
        if (n <= 2) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/div_share_ctrl_if.sv
// -----------------------------------------------------------------------------
// div_share_ctrl_if
// Request/response bundle between NUM_REQ requesters and the shared divider.
//   req_valid/req_ready      per-requester request handshake
//   req_dividend/divisor     packed operands, requester i at [i*DATA_W +: DATA_W]
//   resp_valid/resp_ready    per-requester response handshake (valid one-hot)
//   resp_quotient/remainder  shared result bus, qualified by resp_valid
//   resp_div_by_0            divisor of the current result was zero
// Modports: master = requester side, slave = controller side.
// -----------------------------------------------------------------------------
interface div_share_ctrl_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_dividend;
    logic [NUM_REQ*DATA_W-1:0] req_divisor;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [NUM_REQ-1:0]        resp_ready;
    logic [DATA_W-1:0]         resp_quotient;
    logic [DATA_W-1:0]         resp_remainder;
    logic                      resp_div_by_0;

    modport master (
        output req_valid, req_dividend, req_divisor, resp_ready,
        input  req_ready, resp_valid, resp_quotient, resp_remainder, resp_div_by_0
    );

    modport slave (
        input  req_valid, req_dividend, req_divisor, resp_ready,
        output req_ready, resp_valid, resp_quotient, resp_remainder, resp_div_by_0
    );
endinterface

// File: rtl/div_share_ctrl_rr_arbiter.sv
// -----------------------------------------------------------------------------
// div_share_ctrl_rr_arbiter
// Purely combinational round-robin pick: the first asserted request found
// searching upward from i_last+1, wrapping modulo NUM_REQ.
//   i_req     request vector
//   i_last    index of the most recently served requester
//   o_gnt     one-hot grant (zero when no request)
//   o_gnt_id  encoded grant index
//   o_any     at least one request present
// -----------------------------------------------------------------------------
module div_share_ctrl_rr_arbiter
    import div_share_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    localparam int ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_last,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_gnt_id,
    output logic               o_any
);
    logic [ID_W-1:0] w_idx;

    always_comb begin
        o_gnt    = '0;
        o_gnt_id = '0;
        o_any    = 1'b0;
        w_idx    = '0;
        // k runs 1..NUM_REQ so the last-served requester is considered last
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = ID_W'((int'(i_last) + k) % NUM_REQ);
            if (!o_any && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                o_gnt_id     = w_idx;
                o_any        = 1'b1;
            end
        end
    end
endmodule

// File: rtl/div_share_ctrl.sv
// -----------------------------------------------------------------------------
// div_share_ctrl
// Shares one unsigned combinational divider between NUM_REQ requesters.
// Operands are registered on accept, the divider result is registered one
// cycle later, so the divider sits between two flop stages.
// Sequence per operation: IDLE (accept) -> CALC -> RESP (hold until ready).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         div_share_ctrl_if.slave (request/response handshakes + data)
//   busy        high whenever the controller is not IDLE
// Optional (macro DIV_SHARE_STATS_EN):
//   stat_clr    synchronous clear of the counters (wins over increment)
//   stat_ops    saturating count of completed responses
//   stat_dbz    saturating count of divide-by-zero responses
// -----------------------------------------------------------------------------
module div_share_ctrl
    import div_share_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    div_share_ctrl_if.slave     bus,
    output logic                busy
`ifdef DIV_SHARE_STATS_EN
    ,
    input  logic                stat_clr,
    output logic [31:0]         stat_ops,
    output logic [15:0]         stat_dbz
`endif
);
    localparam int ID_W = id_w(NUM_REQ);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_CALC = ST_CALC;
    localparam logic [1:0] S_RESP = ST_RESP;

    logic [1:0]         r_state;
    logic [ID_W-1:0]    r_last_gnt;
    logic [ID_W-1:0]    r_gnt_id;
    logic [DATA_W-1:0]  r_op_a_p0;
    logic [DATA_W-1:0]  r_op_b_p0;
    logic [DATA_W-1:0]  r_quot_p1;
    logic [DATA_W-1:0]  r_rem_p1;
    logic               r_dbz_p1;

    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_gnt_id;
    logic               w_any;
    logic               w_accept;
    logic               w_done;
    logic [DATA_W-1:0]  w_quot;
    logic [DATA_W-1:0]  w_rem;
    logic               w_dbz;

    div_share_ctrl_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req    (bus.req_valid),
        .i_last   (r_last_gnt),
        .o_gnt    (w_gnt),
        .o_gnt_id (w_gnt_id),
        .o_any    (w_any)
    );

    assign w_accept = (r_state == S_IDLE) && w_any;
    // Only the owner's resp_ready can complete the response
    assign w_done   = (r_state == S_RESP) && bus.resp_ready[r_gnt_id];

    assign bus.req_ready      = (r_state == S_IDLE) ? w_gnt : '0;
    assign bus.resp_valid     = (r_state == S_RESP) ? (NUM_REQ'(1) << r_gnt_id) : '0;
    assign bus.resp_quotient  = r_quot_p1;
    assign bus.resp_remainder = r_rem_p1;
    assign bus.resp_div_by_0  = r_dbz_p1;
    assign busy               = (r_state != S_IDLE);

    // Unsigned divider with DW_div semantics (tc_mode=0, rem_mode=1),
    // including its divide-by-zero outputs: quotient all-ones, remainder =
    // dividend. Written behaviourally so the block builds without the
    // DesignWare library.
    assign w_dbz  = (r_op_b_p0 == '0);
    assign w_quot = w_dbz ? '1        : (r_op_a_p0 / r_op_b_p0);
    assign w_rem  = w_dbz ? r_op_a_p0 : (r_op_a_p0 % r_op_b_p0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_gnt_id   <= '0;
            r_last_gnt <= ID_W'(NUM_REQ - 1);
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_state  <= S_CALC;
                    r_gnt_id <= w_gnt_id;
                end
                S_CALC: r_state <= S_RESP;
                S_RESP: if (w_done) begin
                    r_state    <= S_IDLE;
                    r_last_gnt <= r_gnt_id;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Stage p0: operand capture on accept
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op_a_p0 <= bus.req_dividend[w_gnt_id*DATA_W +: DATA_W];
            r_op_b_p0 <= bus.req_divisor[w_gnt_id*DATA_W +: DATA_W];
        end
    end

    // Stage p1: divider result capture in CALC, held through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quot_p1 <= '0;
            r_rem_p1  <= '0;
            r_dbz_p1  <= 1'b0;
        end else if (r_state == S_CALC) begin
            r_quot_p1 <= w_quot;
            r_rem_p1  <= w_rem;
            r_dbz_p1  <= w_dbz;
        end
    end

`ifdef DIV_SHARE_STATS_EN
    logic [31:0] r_stat_ops;
    logic [15:0] r_stat_dbz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_ops <= '0;
            r_stat_dbz <= '0;
        end else if (stat_clr) begin
            r_stat_ops <= '0;
            r_stat_dbz <= '0;
        end else if (w_done) begin
            if (r_stat_ops != '1)             r_stat_ops <= r_stat_ops + 32'd1;
            if (r_dbz_p1 && r_stat_dbz != '1) r_stat_dbz <= r_stat_dbz + 16'd1;
        end
    end

    assign stat_ops = r_stat_ops;
    assign stat_dbz = r_stat_dbz;
`endif

endmodule
